// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: next-address modes, condition sources, FSM states.
// No logic; constants and types only.
// Imported by the top and by the next-address sub-module.
package microseq_pkg;

  localparam int         UA_W       = 7;
  localparam logic [6:0] FETCH_ADDR = 7'd0;

  // Next-address mode field of the microinstruction.
  typedef enum logic [2:0] {
    NS_INC   = 3'b000,
    NS_JMP   = 3'b001,
    NS_DEC   = 3'b010,
    NS_BR    = 3'b011,
    NS_CALL  = 3'b100,
    NS_RET   = 3'b101,
    NS_FETCH = 3'b110,
    NS_RSVD  = 3'b111
  } ns_e;

  // Branch condition source.
  typedef enum logic [1:0] {
    CS_TRUE  = 2'b00,
    CS_COND  = 2'b01,
    CS_MOC   = 2'b10,
    CS_FALSE = 2'b11
  } cs_e;

  // Sequencer state: free-running or parked on a memory access.
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WAIT_MOC = 1'b1
  } state_e;

endpackage

// File: rtl/microseq_next_addr.sv
// Next-address mux: selects increment/jump/dispatch/branch/call/return/fetch target.
// Purely combinational (zero latency); the parent registers the result.
// No backpressure; the parent decides whether the computed address is taken.
module microseq_next_addr #(
  parameter int              UA_W       = 7,
  parameter logic [UA_W-1:0] FETCH_ADDR = '0
) (
  input  logic [2:0]      ns,
  input  logic [UA_W-1:0] cr_addr,
  input  logic [1:0]      cond_sel,
  input  logic            inv,
  input  logic            cond_pass,
  input  logic            moc,
  input  logic [UA_W-1:0] decode_addr,
  input  logic [UA_W-1:0] upc,
  input  logic [UA_W-1:0] ret_addr,
  output logic [UA_W-1:0] next_addr,
  output logic [UA_W-1:0] inc_addr,
  output logic            is_call
);
  import microseq_pkg::*;

  logic sel_cond;
  logic c;

  // Increment wraps naturally at the top of the microstore.
  assign inc_addr = upc + UA_W'(1);
  assign is_call  = (ns == NS_CALL);
  assign c        = sel_cond ^ inv;

  // Pick the raw condition source before the optional inversion.
  always_comb begin
    sel_cond = 1'b0;
    case (cond_sel)
      CS_TRUE:  sel_cond = 1'b1;
      CS_COND:  sel_cond = cond_pass;
      CS_MOC:   sel_cond = moc;
      default:  sel_cond = 1'b0;
    endcase
  end

  // Mode mux; the reserved encoding falls through to the fetch routine.
  always_comb begin
    next_addr = FETCH_ADDR;
    case (ns)
      NS_INC:  next_addr = inc_addr;
      NS_JMP:  next_addr = cr_addr;
      NS_DEC:  next_addr = decode_addr;
      NS_BR:   next_addr = c ? cr_addr : inc_addr;
      NS_CALL: next_addr = cr_addr;
      NS_RET:  next_addr = ret_addr;
      default: next_addr = FETCH_ADDR;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Microstore next-address controller with one-level call/return and MOC wait/abort.
// upc updates one clock after fields are presented; stall is combinational.
// Holds upc while mfa && !moc; aborts to ABORT_ADDR after MOC_TIMEOUT stalled cycles.
module microsequencer #(
  parameter int              UA_W        = microseq_pkg::UA_W,
  parameter int              MOC_TIMEOUT = 16,
  parameter logic [UA_W-1:0] ABORT_ADDR  = UA_W'(127),
  parameter logic [UA_W-1:0] FETCH_ADDR  = UA_W'(microseq_pkg::FETCH_ADDR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      ns,
  input  logic [UA_W-1:0] cr_addr,
  input  logic [1:0]      cond_sel,
  input  logic            inv,
  input  logic            cond_pass,
  input  logic            mfa,
  input  logic            moc,
  input  logic [UA_W-1:0] decode_addr,
  output logic [UA_W-1:0] upc,
  output logic            stall,
  output logic            moc_timeout
);
  import microseq_pkg::*;

  localparam int              CNT_W     = $clog2(MOC_TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MOC_TIMEOUT - 1);

  state_e           state, state_nxt;
  logic [UA_W-1:0]  ret_addr, ret_nxt;
  logic [UA_W-1:0]  upc_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic             timeout_nxt;
  logic             adv;
  logic [UA_W-1:0]  next_addr;
  logic [UA_W-1:0]  inc_addr;
  logic             is_call;

  assign stall = mfa && !moc;
  assign adv   = !stall;

  microseq_next_addr #(
    .UA_W       (UA_W),
    .FETCH_ADDR (FETCH_ADDR)
  ) u_next_addr (
    .ns          (ns),
    .cr_addr     (cr_addr),
    .cond_sel    (cond_sel),
    .inv         (inv),
    .cond_pass   (cond_pass),
    .moc         (moc),
    .decode_addr (decode_addr),
    .upc         (upc),
    .ret_addr    (ret_addr),
    .next_addr   (next_addr),
    .inc_addr    (inc_addr),
    .is_call     (is_call)
  );

  // State register: upc, return address, wait counter, FSM state and abort pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      upc         <= FETCH_ADDR;
      ret_addr    <= '0;
      wait_cnt    <= '0;
      moc_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      upc         <= upc_nxt;
      ret_addr    <= ret_nxt;
      wait_cnt    <= wait_nxt;
      moc_timeout <= timeout_nxt;
    end
  end

  // Advance on adv from either state; otherwise count stalled cycles and abort at the limit.
  // A call only latches its return address on the cycle it actually advances.
  always_comb begin
    state_nxt   = state;
    upc_nxt     = upc;
    ret_nxt     = ret_addr;
    wait_nxt    = wait_cnt;
    timeout_nxt = 1'b0;
    if (adv) begin
      upc_nxt   = next_addr;
      wait_nxt  = '0;
      state_nxt = ST_RUN;
      if (is_call) begin
        ret_nxt = inc_addr;
      end
    end else begin
      case (state)
        ST_RUN: begin
          wait_nxt  = CNT_W'(1);
          state_nxt = ST_WAIT_MOC;
        end
        default: begin
          if (wait_cnt == WAIT_LAST) begin
            upc_nxt     = ABORT_ADDR;
            timeout_nxt = 1'b1;
            wait_nxt    = '0;
            state_nxt   = ST_RUN;
          end else begin
            wait_nxt = wait_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: sequencing, branches, call/return, MOC wait, abort, async reset.
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ns;
  logic [6:0] cr_addr;
  logic [1:0] cond_sel;
  logic       inv;
  logic       cond_pass;
  logic       mfa;
  logic       moc;
  logic [6:0] decode_addr;
  logic [6:0] upc;
  logic       stall;
  logic       moc_timeout;

  int tests = 0;
  int fails = 0;

  microsequencer dut (
    .clk         (clk),
    .reset       (reset),
    .ns          (ns),
    .cr_addr     (cr_addr),
    .cond_sel    (cond_sel),
    .inv         (inv),
    .cond_pass   (cond_pass),
    .mfa         (mfa),
    .moc         (moc),
    .decode_addr (decode_addr),
    .upc         (upc),
    .stall       (stall),
    .moc_timeout (moc_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [6:0] a);
    ns = 3'b001; cr_addr = a; mfa = 1'b0; moc = 1'b0;
    step();
    chk("jump_to", upc, a);
  endtask

  initial begin
    reset = 1'b1; ns = 3'b000; cr_addr = '0; cond_sel = 2'b00; inv = 1'b0;
    cond_pass = 1'b0; mfa = 1'b0; moc = 1'b0; decode_addr = '0;
    #3;
    chk("reset_upc", upc, 0);
    chk("reset_stall", stall, 0);
    chk("reset_timeout", moc_timeout, 0);
    #9 reset = 1'b0;

    // Sequential increment from the fetch address.
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("inc", upc, i);
    end

    // Wrap from 127 to 0.
    jump_to(7'd127);
    ns = 3'b000;
    step();
    chk("wrap", upc, 0);

    // Conditional branch taken, then inverted (falls through).
    jump_to(7'd5);
    ns = 3'b011; cond_sel = 2'b01; cond_pass = 1'b1; inv = 1'b0; cr_addr = 7'd40;
    step();
    chk("br_taken", upc, 40);
    jump_to(7'd5);
    ns = 3'b011; cond_sel = 2'b01; cond_pass = 1'b1; inv = 1'b1; cr_addr = 7'd40;
    step();
    chk("br_inv", upc, 6);
    ns = 3'b011; cond_sel = 2'b11; inv = 1'b0; cr_addr = 7'd40;
    step();
    chk("br_false", upc, 7);
    ns = 3'b010; decode_addr = 7'd33;
    step();
    chk("decode", upc, 33);
    ns = 3'b111;
    step();
    chk("reserved_fetch", upc, 0);

    // Call and return.
    jump_to(7'd10);
    ns = 3'b100; cr_addr = 7'd80;
    step();
    chk("call", upc, 80);
    ns = 3'b101;
    step();
    chk("ret", upc, 11);

    // MOC wait released after three stalled cycles.
    jump_to(7'd1);
    ns = 3'b001; cr_addr = 7'd2; mfa = 1'b1; moc = 1'b0;
    #1;
    chk("stall_comb", stall, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_hold", upc, 1);
      chk("wait_stall", stall, 1);
    end
    moc = 1'b1;
    #1;
    chk("moc_release_stall", stall, 0);
    step();
    chk("moc_release_upc", upc, 2);

    // MOC as branch condition on the same cycle it releases the access.
    ns = 3'b011; cond_sel = 2'b10; inv = 1'b0; cr_addr = 7'd50; mfa = 1'b1; moc = 1'b1;
    step();
    chk("br_moc", upc, 50);
    cond_sel = 2'b00;

    // Timeout on a stalled call: aborts, return address left untouched.
    jump_to(7'd30);
    ns = 3'b100; cr_addr = 7'd60; mfa = 1'b1; moc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_hold_upc", upc, 30);
      chk("to_no_pulse", moc_timeout, 0);
    end
    step();
    chk("abort_upc", upc, 127);
    chk("abort_pulse", moc_timeout, 1);
    mfa = 1'b0; ns = 3'b101;
    step();
    chk("abort_ret_kept", upc, 11);
    chk("abort_pulse_end", moc_timeout, 0);

    // mfa dropping mid-wait advances normally.
    jump_to(7'd40);
    ns = 3'b000; mfa = 1'b1; moc = 1'b0;
    step();
    step();
    chk("mfa_drop_hold", upc, 40);
    mfa = 1'b0;
    step();
    chk("mfa_drop_adv", upc, 41);

    // Async reset in the middle of a wait (wait count 7).
    jump_to(7'd70);
    ns = 3'b000; mfa = 1'b1; moc = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("pre_reset_hold", upc, 70);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_upc", upc, 0);
    chk("reset_stall_follows", stall, 1);
    step();
    #2 reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("post_reset_hold", upc, 0);
      chk("post_reset_no_pulse", moc_timeout, 0);
    end
    mfa = 1'b0;
    step();
    chk("post_reset_adv", upc, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-address controller for the control unit's 128-entry × 45-bit microstore ROM; drives the ROM's 7-bit index every cycle.
- Consumes the next-state fields decoded from the current microinstruction, the instruction-decoder entry address, the ARM condition result and the memory MOC handshake.
- Supports increment, jump, decode dispatch, conditional branch, one-level call/return, and a MOC wait with timeout abort.

Parameters:
- UA_W, 7, microaddress width (must match ROM index width).
- MOC_TIMEOUT, 16, cycles spent waiting for MOC before aborting (≥2).
- ABORT_ADDR, 7'd127, microaddress entered on a MOC timeout.
- FETCH_ADDR, 7'd0, microaddress of the fetch routine; also the reset target.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ns  in  3  next-address mode from the current microinstruction.
- cr_addr  in  7  jump/branch target field.
- cond_sel  in  2  condition source: 00 = constant 1, 01 = cond_pass, 10 = moc, 11 = constant 0.
- inv  in  1  inverts the selected condition.
- cond_pass  in  1  ARM condition-code test result.
- mfa  in  1  current microinstruction starts/holds a memory access.
- moc  in  1  memory operation complete.
- decode_addr  in  7  entry microaddress from the instruction encoder.
- upc  out  7  current microaddress (ROM index).
- stall  out  1  combinational; high while upc is held waiting for MOC.
- moc_timeout  out  1  registered one-cycle pulse on abort.

Behaviour:
- Reset (async, any time, including mid-wait):
  - upc = FETCH_ADDR, ret_addr = 0, wait_cnt = 0, state = RUN, moc_timeout = 0.
  - First rising edge after reset deassertion computes the next address from upc = 0.
- States: RUN, WAIT_MOC.
- Advance condition (adv) = !(mfa && !moc). stall = mfa && !moc.
- RUN:
  - If adv: upc <= next address; wait_cnt <= 0.
  - Else: hold upc, wait_cnt <= 1, go to WAIT_MOC.
- WAIT_MOC:
  - moc = 1: upc <= next address computed from the held microinstruction fields; wait_cnt <= 0; go to RUN.
  - moc = 0 and wait_cnt == MOC_TIMEOUT−1: upc <= ABORT_ADDR, moc_timeout <= 1 for one cycle, wait_cnt <= 0, ret_addr unchanged, go to RUN.
  - Otherwise: hold upc, wait_cnt++.
  - mfa falling while waiting: treated as adv; advance normally and return to RUN.
- Next-address selection; c = selected condition XOR inv; inc = upc + 1, modulo 128 (127 wraps to 0):
  - 000: inc.
  - 001: cr_addr.
  - 010: decode_addr.
  - 011: c ? cr_addr : inc.
  - 100: call. ret_addr <= inc, next = cr_addr.
  - 101: return. next = ret_addr.
  - 110: FETCH_ADDR.
  - 111: reserved; behaves as 110.
- ret_addr is written only on the cycle a call actually advances; a stalled call does not write it. Nested calls overwrite it (single level).
- cond_sel = 10 combined with mfa: MOC both releases the stall and feeds the branch condition on the same cycle.
- Latency: upc changes one clock after the fields are presented. No combinational path from inputs to upc; stall is combinational from mfa/moc.

Decomposition:
- Shared package microseq_pkg holds:
  - NS_INC, NS_JMP, NS_DEC, NS_BR, NS_CALL, NS_RET, NS_FETCH encodings.
  - CS_TRUE, CS_COND, CS_MOC, CS_FALSE encodings.
  - FETCH_ADDR, UA_W.
- One combinational sub-module, microseq_next_addr: ns/cond mux and incrementer.
- The parent owns upc, ret_addr, wait_cnt, the state and the timeout pulse.

Test Plan:
- Reset, then ns=000 for 3 cycles, mfa=0: upc = 0,1,2,3. Force upc=127 (via jump) then ns=000: upc wraps to 0.
- upc=5, ns=011, cond_sel=01, cond_pass=1, inv=0, cr_addr=40: upc=40. Repeat with inv=1: upc=6.
- upc=10, ns=100, cr_addr=80: upc=80, ret_addr=11. Then ns=101: upc=11.
- upc=1, mfa=1, moc=0 for 3 cycles then moc=1, ns=001, cr_addr=2: stall high 3 cycles, upc=1 held, then upc=2, stall=0.
- mfa=1, moc=0 held with MOC_TIMEOUT=16: after 16 cycles upc=127, moc_timeout pulses once, state back to RUN.
- Assert reset mid-WAIT_MOC at wait_cnt=7: upc=0 immediately (async), stall follows inputs, no timeout pulse after release.
